array_shift_unit: RTL
=====================

ARRAY_SHIFT_UNIT -- requirements
Module: array_shift_unit

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12, element width in bits.
REQ-002 SHALL have parameter NArea, default 4, maximum elements per array (>=2).
REQ-003 SHALL have parameter NArrays, default 4, number of arrays (>=1).
REQ-004 SHALL derive AW=$clog2(NArrays) (min 1) as the array-number width and IW=$clog2(NArea+1) as the index/size width.
REQ-005 SHALL use one clock and a synchronous, active-low reset.
REQ-006 Port: clock  input  1  clock; all state changes on rising edge.
REQ-007 Port: reset  input  1  synchronous active-low reset.
REQ-008 Port: req_valid  input  1  request present.
REQ-009 Port: req_ready  output  1  unit idle, request accepted when req_valid && req_ready.
REQ-010 Port: req_op  input  3  0=write, 1=read, 2=shiftUp, 3=shiftDown, 4=resize, 5-7 illegal.
REQ-011 Port: req_array  input  AW  target array.
REQ-012 Port: req_index  input  IW  element index, or new size for resize.
REQ-013 Port: req_data  input  MemoryElementWidth  write/insert value.
REQ-014 Port: resp_valid  output  1  one-cycle completion pulse.
REQ-015 Port: resp_data  output  MemoryElementWidth  read value or element removed by shiftDown, else 0.
REQ-016 Port: resp_error  output  1  request rejected, no state changed.
REQ-017 Port: resp_size  output  IW  size of target array after the operation.

Function
REQ-018 SHALL hold NArrays*NArea elements, array a element i at a*NArea+i, plus one IW-bit size per array.
REQ-019 FSM states IDLE, SHIFT_UP, SHIFT_DOWN, RESP; req_ready=1 only in IDLE.
REQ-020 Acceptance at edge T; write/read/resize/any error: resp_valid high in cycle T+1, FSM IDLE->RESP->IDLE.
REQ-021 write: index>=NArea -> error; else store data, size=max(size,index+1).
REQ-022 read: index>=size -> error, resp_data=0; else resp_data=element.
REQ-023 resize: index>NArea -> error; else size=index, elements beyond size retain contents.
REQ-024 shiftUp at p with size s: s==NArea or p>s -> error; else move elements s-1 down to p up one slot, one element per cycle, highest first, then write data at p, size=s+1.
REQ-025 shiftUp latency: resp_valid in cycle T+(s-p)+1 (p==s: T+1, plain append).
REQ-026 shiftDown at p: s==0 or p>=s -> error; else capture element p, move elements p+1..s-1 down one slot one per cycle lowest first, size=s-1, resp_data=captured element.
REQ-027 shiftDown latency: resp_valid in cycle T+(s-p-1)+1, minimum T+1.
REQ-028 Only the target array SHALL change; neighbouring arrays' elements bit-exact unchanged, including at array boundaries.
REQ-029 Illegal op (5-7) -> error, latency T+1.
REQ-030 resp_valid/resp_error/resp_data/resp_size SHALL be registered, valid only when resp_valid=1, and 0 otherwise; no response backpressure.
REQ-031 req_valid while not ready SHALL be ignored; requester holds request.
REQ-032 Back-to-back: new request acceptable in the cycle after resp_valid (IDLE), giving one request every 2 cycles minimum.

Reset
REQ-033 With reset=0 at an edge: state IDLE, all sizes 0, all elements 0, req_ready=1 next cycle, resp_valid=resp_error=0, resp_data=resp_size=0.
REQ-034 Reset mid-shift SHALL abort the operation with no response pulse; reset takes priority over any request.

Verification
REQ-035 Array 1: write idx0=0, idx1=1, idx2=2 -> each resp_size 1,2,3, no error; array 0 and 2 elements remain 0.
REQ-036 Then shiftUp array1 p=0 data=99 -> resp_valid 4 cycles after acceptance, resp_size=4; reads idx0..3 return 99,0,1,2.
REQ-037 Then shiftUp array1 (full) -> resp_error=1 at T+1, size 4, contents unchanged; read idx4 -> error.
REQ-038 Then shiftDown array1 p=1 -> resp_data=0, resp_size=3 at T+3; reads return 99,1,2; shiftDown on empty array 0 -> error.
REQ-039 Start shiftUp array1 p=0 on size-3 array, drive reset=0 in cycle T+2 -> no resp_valid; afterwards every read errors, all sizes 0.
REQ-040 write idx=NArea, resize to NArea+1, op=6 -> each resp_error=1 at T+1 with no state change.

Source files
------------

// File: rtl/array_shift_unit.sv
// array_shift_unit
// Holds NArrays independent arrays of up to NArea elements each, plus a
// current size per array. One request is served at a time. A request can
// write, read, resize, insert (shiftUp) or remove (shiftDown) an element.
// Insert and remove move one element per clock inside the target array only.
//
// Ports
//   clock, reset            : rising-edge clock, synchronous active-low reset
//   req_valid/req_ready     : request handshake (see below)
//   req_op                  : 0 write, 1 read, 2 shiftUp, 3 shiftDown, 4 resize
//   req_array/req_index     : target array, element index (new size on resize)
//   req_data                : value to write / insert
//   resp_valid              : one-cycle completion pulse
//   resp_error              : request rejected, nothing changed
//   resp_data               : read value or removed element, else 0
//   resp_size               : size of the target array after the operation
//   o_dbg_state             : current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only while idle; a request presented while busy is ignored
// and must be held. Responses cannot be stalled; all resp_* outputs are
// registered and read as 0 whenever resp_valid is 0.
module array_shift_unit #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 4,
  parameter int NArrays            = 4,
  localparam int AW = (NArrays > 1) ? $clog2(NArrays) : 1,
  localparam int IW = $clog2(NArea + 1),
  localparam int FW = (NArrays * NArea > 1) ? $clog2(NArrays * NArea) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [2:0]                    req_op,
  input  logic [AW-1:0]                 req_array,
  input  logic [IW-1:0]                 req_index,
  input  logic [MemoryElementWidth-1:0] req_data,
  output logic                          resp_valid,
  output logic [MemoryElementWidth-1:0] resp_data,
  output logic                          resp_error,
  output logic [IW-1:0]                 resp_size,
  output logic [1:0]                    o_dbg_state
);

  localparam int MD = 1 << FW;  // storage rounded up so every address is in range
  localparam int SD = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SHIFT_UP   = 2'd1,
    ST_SHIFT_DOWN = 2'd2,
    ST_RESP       = 2'd3
  } state_t;

  state_t                          r_state;
  logic [MemoryElementWidth-1:0]   r_mem  [MD];
  logic [IW-1:0]                   r_size [SD];
  logic [AW-1:0]                   r_arr;
  logic [IW-1:0]                   r_p;     // operation position
  logic [IW-1:0]                   r_pos;   // slot being written this cycle
  logic [MemoryElementWidth-1:0]   r_data;
  logic [MemoryElementWidth-1:0]   r_cap;   // element removed by shiftDown

  logic [IW-1:0]                   w_size;
  logic                            w_arr_ok;
  logic [FW-1:0]                   w_addr;
  logic [FW-1:0]                   w_cur;
  logic [IW-1:0]                   w_wr_size;
  logic                            w_err;

  assign req_ready   = (r_state == ST_IDLE);
  assign o_dbg_state = r_state;

  assign w_size    = r_size[req_array];
  assign w_arr_ok  = (32'(req_array) < NArrays);
  assign w_addr    = FW'(req_array) * FW'(NArea) + FW'(req_index);
  assign w_cur     = FW'(r_arr) * FW'(NArea) + FW'(r_pos);
  assign w_wr_size = (req_index >= w_size) ? req_index + IW'(1) : w_size;

  always_comb begin
    w_err = 1'b0;
    if (!w_arr_ok) begin
      w_err = 1'b1;
    end else begin
      case (req_op)
        3'd0:    w_err = (32'(req_index) >= NArea);
        3'd1:    w_err = (req_index >= w_size);
        3'd2:    w_err = (32'(w_size) == NArea) || (req_index > w_size);
        3'd3:    w_err = (w_size == '0) || (req_index >= w_size);
        3'd4:    w_err = (32'(req_index) > NArea);
        default: w_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_arr      <= '0;
      r_p        <= '0;
      r_pos      <= '0;
      r_data     <= '0;
      r_cap      <= '0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_data  <= '0;
      resp_size  <= '0;
      for (int k = 0; k < MD; k++) r_mem[k] <= '0;
      for (int k = 0; k < SD; k++) r_size[k] <= '0;
    end else begin
      // Response outputs are pulses; cleared unless set below.
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_data  <= '0;
      resp_size  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_arr   <= req_array;
            r_p     <= req_index;
            r_data  <= req_data;
            r_state <= ST_RESP;
            if (w_err) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_size  <= w_arr_ok ? w_size : '0;
            end else begin
              case (req_op)
                3'd0: begin
                  r_mem[w_addr]     <= req_data;
                  r_size[req_array] <= w_wr_size;
                  resp_valid        <= 1'b1;
                  resp_size         <= w_wr_size;
                end
                3'd1: begin
                  resp_valid <= 1'b1;
                  resp_data  <= r_mem[w_addr];
                  resp_size  <= w_size;
                end
                3'd2: begin
                  if (req_index == w_size) begin
                    // Append: nothing to move.
                    r_mem[w_addr]     <= req_data;
                    r_size[req_array] <= w_size + IW'(1);
                    resp_valid        <= 1'b1;
                    resp_size         <= w_size + IW'(1);
                  end else begin
                    r_pos   <= w_size;
                    r_state <= ST_SHIFT_UP;
                  end
                end
                3'd3: begin
                  r_cap <= r_mem[w_addr];
                  if (req_index == w_size - IW'(1)) begin
                    // Removing the last element: nothing to move.
                    r_size[req_array] <= w_size - IW'(1);
                    resp_valid        <= 1'b1;
                    resp_data         <= r_mem[w_addr];
                    resp_size         <= w_size - IW'(1);
                  end else begin
                    r_pos   <= req_index;
                    r_state <= ST_SHIFT_DOWN;
                  end
                end
                default: begin
                  // resize: contents beyond the new size are kept.
                  r_size[req_array] <= req_index;
                  resp_valid        <= 1'b1;
                  resp_size         <= req_index;
                end
              endcase
            end
          end
        end
        ST_SHIFT_UP: begin
          // Highest element first, so each source is read before it is overwritten.
          r_mem[w_cur] <= r_mem[w_cur - FW'(1)];
          if (r_pos == r_p + IW'(1)) begin
            r_mem[w_cur - FW'(1)] <= r_data;
            r_size[r_arr]         <= r_size[r_arr] + IW'(1);
            resp_valid            <= 1'b1;
            resp_size             <= r_size[r_arr] + IW'(1);
            r_state               <= ST_RESP;
          end else begin
            r_pos <= r_pos - IW'(1);
          end
        end
        ST_SHIFT_DOWN: begin
          // Lowest element first; the old top slot keeps its stale value.
          r_mem[w_cur] <= r_mem[w_cur + FW'(1)];
          if (r_pos == r_size[r_arr] - IW'(2)) begin
            r_size[r_arr] <= r_size[r_arr] - IW'(1);
            resp_valid    <= 1'b1;
            resp_data     <= r_cap;
            resp_size     <= r_size[r_arr] - IW'(1);
            r_state       <= ST_RESP;
          end else begin
            r_pos <= r_pos + IW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
